// File: rtl/uart_rx_ctl.sv
// rtl/uart_rx_ctl.sv - 8N1 UART receiver with one-entry holding register
//
// Receives asynchronous serial frames on rx (idle high, start bit low, 8 data
// bits LSB first, one stop bit) and presents each byte through a one-entry
// holding register with a valid/ready handshake.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
//   SYNC_STAGES   flip-flops in the rx synchroniser (>= 2)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   rx            asynchronous serial input, idles high
//   data          received byte, stable while valid=1
//   valid         holding register contains an unread byte
//   ready         consumer takes the byte when valid && ready at a clk edge
//   frame_error   one-cycle pulse when the stop bit is sampled low
//   overrun       sticky, a byte was dropped because the holder was full
//   busy          receive FSM is not idle
//   parity_error  (UART_RX_PARITY_EN only) one-cycle pulse on bad even parity
//
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit, plus the parity_error output.

module uart_rx_ctl #(
    parameter int CLKS_PER_BIT = 234,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    // Mid-start-bit and end-of-bit compare points for the baud counter.
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    // ------------------------------------------------------------------
    // rx synchroniser. Reset value is 1 (line idle) so that leaving reset
    // never looks like a falling start edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rs = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          state,   state_n;
    logic [BW-1:0]   bcnt,    bcnt_n;
    logic [2:0]      bidx,    bidx_n;
    logic [7:0]      shreg,   shreg_n;
    logic            deliver, deliver_n;   // stop bit good, load holder next edge
    logic            ferr_n;
`ifdef UART_RX_PARITY_EN
    logic            pbad,    pbad_n;      // current frame failed parity
    logic            perr_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bcnt         <= '0;
            bidx         <= '0;
            shreg        <= '0;
            deliver      <= 1'b0;
            frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad         <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            bcnt         <= bcnt_n;
            bidx         <= bidx_n;
            shreg        <= shreg_n;
            deliver      <= deliver_n;
            frame_error  <= ferr_n;
`ifdef UART_RX_PARITY_EN
            pbad         <= pbad_n;
            parity_error <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        bcnt_n    = bcnt;
        bidx_n    = bidx;
        shreg_n   = shreg;
        deliver_n = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_n    = pbad;
        perr_n    = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (!rs) begin
                    state_n = S_START;
                    bcnt_n  = '0;
`ifdef UART_RX_PARITY_EN
                    pbad_n  = 1'b0;
`endif
                end
            end

            // Re-check the line at mid start bit; a pulse shorter than half
            // a bit is treated as noise.
            S_START: begin
                if (bcnt == HALF_M1) begin
                    if (rs) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DATA;
                        bcnt_n  = '0;
                        bidx_n  = '0;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end

            // The counter was aligned to mid start bit, so a full bit period
            // later lands at the middle of each data bit.
            S_DATA: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n  = '0;
                    shreg_n = {rs, shreg[7:1]};
                    if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bidx_n = bidx + 3'd1;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: data bits XOR parity bit must be 0. A bad byte is
            // still framed normally but never reaches the holding register.
            S_PARITY: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n  = '0;
                    state_n = S_STOP;
                    if ((^shreg) ^ rs) begin
                        perr_n = 1'b1;
                        pbad_n = 1'b1;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end
`endif

            // Returning to IDLE at mid stop bit leaves half a bit of margin
            // for a back-to-back start edge.
            S_STOP: begin
                if (bcnt == FULL_M1) begin
                    bcnt_n = '0;
                    if (rs) begin
                        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        deliver_n = !pbad;
`else
                        deliver_n = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end

            // A line held low after a framing error must go high before a new
            // start bit can be recognised.
            S_BREAK: begin
                if (rs) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Holding register and handshake. A load while the consumer is taking
    // the previous byte is not an overrun; any accepted handshake clears the
    // sticky overrun flag even when a new byte lands on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (deliver) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (valid && ready) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctl.sv
// tb/tb_uart_rx_ctl.sv - directed self-checking bench for uart_rx_ctl

module tb_uart_rx_ctl;

    localparam int CPB = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int nerr = 0;
    int nchk = 0;

    int         vcyc  = 0;
    int         fecnt = 0;
    int         pecnt = 0;
    logic       vprev = 1'b0;
    logic [7:0] cap[$];

    int         vb;
    int         fb;
    int         pb;
    int         base;

    uart_rx_ctl #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    always #5 clk = ~clk;

    // Observers on the falling edge: valid cycles, delivered bytes, error pulses.
    always @(negedge clk) begin
        vprev <= valid;
        if (valid) vcyc <= vcyc + 1;
        if (valid && !vprev) cap.push_back(data);
        if (frame_error) fecnt <= fecnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pecnt <= pecnt + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int idx);
        if (idx < cap.size()) return {24'd0, cap[idx]};
        return 32'hDEAD;
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stopb);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_p(input logic [7:0] b, input logic p);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(1'b1);
    endtask
`endif

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",    {24'd0, data}, 32'h0);
        chk("rst_valid",   {31'd0, valid}, 32'h0);
        chk("rst_ferr",    {31'd0, frame_error}, 32'h0);
        chk("rst_overrun", {31'd0, overrun}, 32'h0);
        chk("rst_busy",    {31'd0, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(4);

        // Back-to-back 0x55, 0xA3 with ready held high
        ready = 1'b1;
        base  = cap.size();
        vb    = vcyc;
        fb    = fecnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        idle(6);
        @(negedge clk);
        chk("b2b_byte0",   cap_at(base), 32'h55);
        chk("b2b_byte1",   cap_at(base + 1), 32'hA3);
        chk("b2b_vcycles", vcyc - vb, 32'd2);
        chk("b2b_valid",   {31'd0, valid}, 32'h0);
        chk("b2b_overrun", {31'd0, overrun}, 32'h0);
        chk("b2b_ferr",    fecnt - fb, 32'd0);

        // Overrun: 0x12 then 0x34 with ready low
        @(posedge clk); #1;
        ready = 1'b0;
        send_frame(8'h12, 1'b1);
        idle(4);
        @(negedge clk);
        chk("ovr_first_valid", {31'd0, valid}, 32'h1);
        chk("ovr_first_flag",  {31'd0, overrun}, 32'h0);
        @(posedge clk); #1;
        send_frame(8'h34, 1'b1);
        idle(6);
        @(negedge clk);
        chk("ovr_data",  {24'd0, data}, 32'h12);
        chk("ovr_valid", {31'd0, valid}, 32'h1);
        chk("ovr_flag",  {31'd0, overrun}, 32'h1);
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        chk("ovr_clr_valid", {31'd0, valid}, 32'h0);
        chk("ovr_clr_flag",  {31'd0, overrun}, 32'h0);

        // Glitch shorter than half a bit
        @(posedge clk); #1;
        ready = 1'b1;
        vb    = vcyc;
        rx    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy_hi", {31'd0, busy}, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("glitch_busy_lo", {31'd0, busy}, 32'h0);
        chk("glitch_valid",   vcyc - vb, 32'd0);

        // Framing error, line held low, then recovery
        @(posedge clk); #1;
        vb = vcyc;
        fb = fecnt;
        send_frame(8'hFF, 1'b0);
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        chk("brk_ferr_once", fecnt - fb, 32'd1);
        chk("brk_busy_low",  {31'd0, busy}, 32'h1);
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        chk("brk_idle",      {31'd0, busy}, 32'h0);
        chk("brk_no_retrig", fecnt - fb, 32'd1);
        chk("brk_no_valid",  vcyc - vb, 32'd0);
        @(posedge clk); #1;
        base = cap.size();
        vb   = vcyc;
        send_frame(8'h7E, 1'b1);
        idle(6);
        @(negedge clk);
        chk("brk_next_byte", cap_at(base), 32'h7E);
        chk("brk_next_vcyc", vcyc - vb, 32'd1);

        // Reset during bit 4 of 0xA5
        @(posedge clk); #1;
        ready = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_busy",     {31'd0, busy}, 32'h1);
        chk("mid_old_data", {24'd0, data}, 32'h7E);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_data",    {24'd0, data}, 32'h0);
        chk("mrst_valid",   {31'd0, valid}, 32'h0);
        chk("mrst_ferr",    {31'd0, frame_error}, 32'h0);
        chk("mrst_overrun", {31'd0, overrun}, 32'h0);
        chk("mrst_busy",    {31'd0, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(8);
        ready = 1'b1;
        base  = cap.size();
        vb    = vcyc;
        send_frame(8'hC3, 1'b1);
        idle(6);
        @(negedge clk);
        chk("mrst_next_byte", cap_at(base), 32'hC3);
        chk("mrst_next_vcyc", vcyc - vb, 32'd1);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x01 needs parity bit 1
        @(posedge clk); #1;
        pb = pecnt;
        vb = vcyc;
        send_frame_p(8'h01, 1'b0);
        idle(6);
        @(negedge clk);
        chk("par_bad_pulse", pecnt - pb, 32'd1);
        chk("par_bad_valid", vcyc - vb, 32'd0);
        @(posedge clk); #1;
        base = cap.size();
        vb   = vcyc;
        pb   = pecnt;
        send_frame_p(8'h01, 1'b1);
        idle(6);
        @(negedge clk);
        chk("par_ok_byte",  cap_at(base), 32'h01);
        chk("par_ok_vcyc",  vcyc - vb, 32'd1);
        chk("par_ok_nopls", pecnt - pb, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
